aes_round_ctrl: RTL
===================

// Module: aes_round_ctrl
// PURPOSE
//  Sequences the AES round datapath for one 128-bit block. Starts on ld_i from the input
//  buffer, then runs the initial AddRoundKey and NR rounds, driving round index, Rcon,
//  last-round and key-expansion enables. Holds the result until the consumer accepts it,
//  then pulses done_o so the input buffer rearms.
// PARAMETERS
//  NR     10  number of rounds (legal: 10, 12, 14)
//  CNT_W  16  width of completed-block counter (AES_PERF_CNT_EN only)
// PORTS
//  clk           in   1      clock; all state changes on posedge
//  rst           in   1      reset, synchronous, active-low
//  ld_i          in   1      block+key loaded (1-cycle pulse from input buffer)
//  out_ready_i   in   1      consumer accepts result
//  init_o        out  1      select loaded text into state reg, initial AddRoundKey
//  round_o       out  4      current round index (0 = init)
//  rcon_o        out  8      round constant for round_o
//  kexp_en_o     out  1      advance key schedule this cycle
//  last_round_o  out  1      final round: datapath bypasses MixColumns
//  busy_o        out  1      not IDLE
//  valid_o       out  1      result valid, held until accepted
//  done_o        out  1      1-cycle pulse on valid_o && out_ready_i
//  ld_ovf_o      out  1      1-cycle pulse: ld_i dropped while busy
//  blk_cnt_o     out  CNT_W  completed-block count
// BEHAVIOUR
//  - Reset (rst==0 at posedge): state=IDLE, round=0, rcon=8'h01, all outputs 0. Wins over
//    every other input, including mid-block; the block in flight is abandoned, no done_o.
//  - FSM, registered state, Moore outputs except done_o/ld_ovf_o:
//    IDLE : busy_o=0. ld_i -> INIT.
//    INIT : one cycle. init_o=1, round_o=0. -> ROUND, round=1, rcon=8'h01.
//    ROUND: kexp_en_o=1, round_o=round, rcon_o=rcon, last_round_o=(round==NR).
//           round<NR: round+=1, rcon=xtime(rcon) = {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 0).
//           round==NR -> HOLD.
//    HOLD : valid_o=1. out_ready_i -> done_o=1 (same cycle, combinational from
//           valid_o && out_ready_i). Next state is INIT if ld_i is 1 that cycle, else IDLE.
//  - Latency: ld_i at cycle 0 -> INIT at cycle 1 -> rounds at cycles 2..NR+1 ->
//    valid_o at cycle NR+2. With out_ready_i tied 1, blocks run back-to-back every NR+2 cycles.
//  - Rcon per round for NR=10: 01 02 04 08 10 20 40 80 1b 36.
//  - Outside ROUND: rcon_o=0 and kexp_en_o=0.
//  - ld_i in INIT/ROUND, or in HOLD without out_ready_i: ignored, ld_ovf_o=1 that cycle,
//    sequence undisturbed.
//  - out_ready_i outside HOLD: ignored.
//  - round counter width is 4 bits; it never exceeds NR, so it never wraps.
// CONFIGURATION
//  AES_PERF_CNT_EN defined: blk_cnt_o increments on each done_o and saturates at all-ones.
//    Reset to 0.
//  Not defined: no counter logic; blk_cnt_o is tied to 0 and the port remains.
// TESTING
//  1. Reset, ld_i pulse, out_ready_i=1 -> init_o at cyc1; rcon 01..36 over cyc2..11;
//     last_round_o only at cyc11; valid_o+done_o at cyc12.
//  2. out_ready_i=0 for 5 cycles after valid_o -> valid_o held 5 cycles, done_o=0, then one
//     done_o pulse on ready.
//  3. ld_i during round 4 -> ld_ovf_o pulse, round/rcon sequence unchanged, done_o still at cyc12.
//  4. ld_i coincident with HOLD handshake -> done_o=1 and INIT the next cycle, no ld_ovf_o.
//  5. rst=0 during round 6 -> next cycle IDLE, all outputs 0. New ld_i restarts at round 0
//     with rcon 01.
//  6. AES_PERF_CNT_EN, CNT_W=2, 5 blocks -> blk_cnt_o 1,2,3,3,3; undefined -> blk_cnt_o=0.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: runs the initial AddRoundKey and NR rounds for one block,
// then holds the result for the consumer. Optional block counter under AES_PERF_CNT_EN.
module aes_round_ctrl #(
    parameter int NR    = 10,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_i,
    input  logic             out_ready_i,
    output logic             init_o,
    output logic [3:0]       round_o,
    output logic [7:0]       rcon_o,
    output logic             kexp_en_o,
    output logic             last_round_o,
    output logic             busy_o,
    output logic             valid_o,
    output logic             done_o,
    output logic             ld_ovf_o,
    output logic [CNT_W-1:0] blk_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INIT  = 2'd1,
        ST_ROUND = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam logic [3:0] NR_L = 4'(NR);

    generate
        if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
            $error("aes_round_ctrl: NR must be 10, 12 or 14");
        end
    endgenerate

    // GF(2^8) doubling used to step the round constant
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    state_t     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic [7:0] rcon_q, rcon_d;

    logic       init_q, init_d;
    logic [3:0] round_out_q, round_out_d;
    logic [7:0] rcon_out_q, rcon_out_d;
    logic       kexp_en_q, kexp_en_d;
    logic       last_round_q, last_round_d;
    logic       busy_q, busy_d;
    logic       valid_q, valid_d;

    // Next-state, round index and round constant
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        case (state_q)
            ST_IDLE: begin
                if (ld_i) begin
                    state_d = ST_INIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_INIT: begin
                state_d = ST_ROUND;
                round_d = 4'd1;
                rcon_d  = 8'h01;
            end
            ST_ROUND: begin
                if (round_q == NR_L) begin
                    state_d = ST_HOLD;
                    round_d = 4'd0;
                    rcon_d  = 8'h01;
                end else begin
                    state_d = ST_ROUND;
                    round_d = round_q + 4'd1;
                    rcon_d  = xtime(rcon_q);
                end
            end
            ST_HOLD: begin
                if (out_ready_i) begin
                    state_d = ld_i ? ST_INIT : ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                round_d = 4'd0;
                rcon_d  = 8'h01;
            end
        endcase
    end

    // Moore outputs are decoded from the next state so they can be flopped
    always_comb begin
        init_d       = (state_d == ST_INIT);
        kexp_en_d    = (state_d == ST_ROUND);
        round_out_d  = (state_d == ST_ROUND) ? round_d : 4'd0;
        rcon_out_d   = (state_d == ST_ROUND) ? rcon_d : 8'h00;
        last_round_d = (state_d == ST_ROUND) && (round_d == NR_L);
        busy_d       = (state_d != ST_IDLE);
        valid_d      = (state_d == ST_HOLD);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            round_q      <= 4'd0;
            rcon_q       <= 8'h01;
            init_q       <= 1'b0;
            round_out_q  <= 4'd0;
            rcon_out_q   <= 8'h00;
            kexp_en_q    <= 1'b0;
            last_round_q <= 1'b0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            round_q      <= round_d;
            rcon_q       <= rcon_d;
            init_q       <= init_d;
            round_out_q  <= round_out_d;
            rcon_out_q   <= rcon_out_d;
            kexp_en_q    <= kexp_en_d;
            last_round_q <= last_round_d;
            busy_q       <= busy_d;
            valid_q      <= valid_d;
        end
    end

    assign init_o       = init_q;
    assign round_o      = round_out_q;
    assign rcon_o       = rcon_out_q;
    assign kexp_en_o    = kexp_en_q;
    assign last_round_o = last_round_q;
    assign busy_o       = busy_q;
    assign valid_o      = valid_q;

    // A load is only accepted from IDLE or from a completing HOLD handshake
    assign done_o   = valid_q && out_ready_i;
    assign ld_ovf_o = ld_i && ((state_q == ST_INIT) || (state_q == ST_ROUND) ||
                               ((state_q == ST_HOLD) && !out_ready_i));

`ifdef AES_PERF_CNT_EN
    logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;

    // Saturating completed-block count
    always_comb begin
        if (done_o && (blk_cnt_q != {CNT_W{1'b1}})) begin
            blk_cnt_d = blk_cnt_q + CNT_W'(1);
        end else begin
            blk_cnt_d = blk_cnt_q;
        end
    end

    // Block counter register
    always_ff @(posedge clk) begin
        if (!rst) begin
            blk_cnt_q <= {CNT_W{1'b0}};
        end else begin
            blk_cnt_q <= blk_cnt_d;
        end
    end

    assign blk_cnt_o = blk_cnt_q;
`else
    assign blk_cnt_o = {CNT_W{1'b0}};
`endif

endmodule
